// File: rtl/updown_pkg.sv
// updown_pkg: shared direction and mode encodings for the up/down counter family.
package updown_pkg;
    localparam logic INST_UP = 1'b0;
    localparam logic INST_DOWN = 1'b1;
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT = 1;
endpackage

// File: rtl/updown_counter_param_if.sv
// updown_counter_param_if: control inputs and count/flag outputs of the up/down counter.
interface updown_counter_param_if #(
    parameter int WIDTH = 32,
    parameter int STEP_W = 4
);
    logic en;
    logic inst;
    logic [STEP_W-1:0] step;
    logic load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] value;
    logic at_max;
    logic at_min;
    logic overflow;
    logic underflow;
    modport master (
        output en, inst, step, load, load_value,
        input value, at_max, at_min, overflow, underflow
    );
    modport slave (
        input en, inst, step, load, load_value,
        output value, at_max, at_min, overflow, underflow
    );
endinterface

// File: rtl/updown_next_calc.sv
// updown_next_calc: combinational next count and wrap/clamp flags for one step.
module updown_next_calc
    import updown_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] MAX_VALUE = '1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] value,
    input  logic             inst,
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] next_value,
    output logic             ovf,
    output logic             unf
);
    localparam logic [WIDTH:0] MX = {1'b0, MAX_VALUE};
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);
    localparam bit SAT = SATURATE == MODE_SAT;
    logic up;
    logic [WIDTH:0] sum, wrap_up, wrap_dn, nxt;
    logic unused_msb;
    always_comb begin
        up = inst == INST_UP;
        sum = {1'b0, value} + {1'b0, s};
        ovf = up && sum > MX;
        unf = !up && s > value;
        wrap_up = sum - MX - ONE;
        // (MX - s) is non-negative since s is pre-clamped, so no intermediate wraps
        wrap_dn = {1'b0, value} + (MX - {1'b0, s}) + ONE;
        nxt = up ? (ovf ? (SAT ? MX : wrap_up) : sum)
                 : (unf ? (SAT ? '0 : wrap_dn) : {1'b0, value} - {1'b0, s});
    end
    assign next_value = nxt[WIDTH-1:0];
    assign unused_msb = nxt[WIDTH];
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: bounded up/down counter with step, load, wrap/saturate and flags.
module updown_counter_param
    import updown_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] MAX_VALUE = '1,
    parameter int STEP_W = 4,
    parameter int SATURATE = MODE_WRAP
) (
    input logic clock,
    input logic reset,
    updown_counter_param_if.slave bus
);
    logic [WIDTH-1:0] value, step_ext, s, load_clamped, next_value;
    logic at_max, at_min, overflow, underflow, ovf, unf;
    always_comb begin
        step_ext = WIDTH'(bus.step);
        s = step_ext > MAX_VALUE ? MAX_VALUE : step_ext;
        load_clamped = bus.load_value > MAX_VALUE ? MAX_VALUE : bus.load_value;
    end
    updown_next_calc #(
        .WIDTH(WIDTH),
        .MAX_VALUE(MAX_VALUE),
        .SATURATE(SATURATE)
    ) calc (
        .value(value),
        .inst(bus.inst),
        .s(s),
        .next_value(next_value),
        .ovf(ovf),
        .unf(unf)
    );
    always_ff @(posedge clock) begin
        if (!reset) begin
            value <= '0;
            at_max <= 1'b0;
            at_min <= 1'b1;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.load) begin
            value <= load_clamped;
            at_max <= load_clamped == MAX_VALUE;
            at_min <= load_clamped == '0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.en) begin
            value <= next_value;
            at_max <= next_value == MAX_VALUE;
            at_min <= next_value == '0;
            overflow <= ovf;
            underflow <= unf;
        end else begin
            overflow <= 1'b0;
            underflow <= 1'b0;
        end
    end
    assign bus.value = value;
    assign bus.at_max = at_max;
    assign bus.at_min = at_min;
    assign bus.overflow = overflow;
    assign bus.underflow = underflow;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: scoreboard bench over wrap, saturate and 32-bit counter instances.
module tb_updown_counter_param;
    logic clk = 1'b0;
    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    int checks = 0;
    int failures = 0;
    typedef struct {
        int d;
        string name;
        logic [31:0] v;
        logic amax, amin, ovf, unf;
    } exp_t;
    exp_t q[$];
    always #5 clk = ~clk;
    updown_counter_param_if #(.WIDTH(8), .STEP_W(4)) if0 ();
    updown_counter_param_if #(.WIDTH(8), .STEP_W(4)) if1 ();
    updown_counter_param_if #(.WIDTH(32), .STEP_W(4)) if2 ();
    updown_counter_param #(.WIDTH(8), .MAX_VALUE(8'd200), .STEP_W(4), .SATURATE(0))
        dut0 (.clock(clk), .reset(rst0), .bus(if0));
    updown_counter_param #(.WIDTH(8), .MAX_VALUE(8'd200), .STEP_W(4), .SATURATE(1))
        dut1 (.clock(clk), .reset(rst1), .bus(if1));
    updown_counter_param #(.WIDTH(32), .STEP_W(4), .SATURATE(0))
        dut2 (.clock(clk), .reset(rst2), .bus(if2));
    function automatic logic [31:0] max_of(int d);
        return d == 2 ? 32'hFFFF_FFFF : 32'd200;
    endfunction
    task automatic idle_all();
        {rst0, rst1, rst2} = 3'b111;
        {if0.en, if0.load, if0.inst, if0.step, if0.load_value} = '0;
        {if1.en, if1.load, if1.inst, if1.step, if1.load_value} = '0;
        {if2.en, if2.load, if2.inst, if2.step, if2.load_value} = '0;
    endtask
    task automatic push(int d, string name, logic [31:0] ev, bit eo, bit eu);
        exp_t e;
        e.d = d; e.name = name; e.v = ev; e.ovf = eo; e.unf = eu;
        e.amax = ev == max_of(d);
        e.amin = ev == 0;
        q.push_back(e);
    endtask
    task automatic cyc(int d, string name, bit rn, bit ld, logic [31:0] lv, bit e, bit in,
                       logic [3:0] st, logic [31:0] ev, bit eo, bit eu);
        @(negedge clk);
        idle_all();
        case (d)
            0: begin rst0 = rn; if0.load = ld; if0.load_value = lv[7:0]; if0.en = e; if0.inst = in; if0.step = st; end
            1: begin rst1 = rn; if1.load = ld; if1.load_value = lv[7:0]; if1.en = e; if1.inst = in; if1.step = st; end
            default: begin rst2 = rn; if2.load = ld; if2.load_value = lv; if2.en = e; if2.inst = in; if2.step = st; end
        endcase
        push(d, name, ev, eo, eu);
    endtask
    initial begin : monitor
        exp_t e;
        logic [35:0] act, want;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.d)
                    0: act = {24'b0, if0.value, if0.at_max, if0.at_min, if0.overflow, if0.underflow};
                    1: act = {24'b0, if1.value, if1.at_max, if1.at_min, if1.overflow, if1.underflow};
                    default: act = {if2.value, if2.at_max, if2.at_min, if2.overflow, if2.underflow};
                endcase
                want = {e.v, e.amax, e.amin, e.ovf, e.unf};
                checks++;
                if (act !== want) begin
                    failures++;
                    $display("FAIL %s dut%0d: got value=%0h max/min/ovf/unf=%b, want value=%0h max/min/ovf/unf=%b",
                             e.name, e.d, act[35:4], act[3:0], want[35:4], want[3:0]);
                end
            end
        end
    end
    initial begin
        idle_all();
        @(negedge clk);
        {rst0, rst1, rst2} = 3'b000;
        for (int d = 0; d < 3; d++) push(d, "reset", 0, 0, 0);
        // wrap counter: counting, mid-run reset, overflow/underflow wrap
        for (int i = 1; i <= 5; i++) cyc(0, "count_up", 1, 0, 0, 1, 0, 1, i, 0, 0);
        cyc(0, "reset_mid", 0, 1, 50, 1, 0, 1, 0, 0, 0);
        cyc(0, "load198", 1, 1, 198, 0, 0, 0, 198, 0, 0);
        cyc(0, "wrap_up", 1, 0, 0, 1, 0, 5, 2, 1, 0);
        cyc(0, "ovf_pulse_end", 1, 0, 0, 0, 0, 0, 2, 0, 0);
        cyc(0, "wrap_down", 1, 0, 0, 1, 1, 5, 198, 0, 1);
        cyc(0, "down_plain", 1, 0, 0, 1, 1, 5, 193, 0, 0);
        cyc(0, "load_clamp", 1, 1, 250, 1, 0, 9, 200, 0, 0);
        cyc(0, "wrap_at_max", 1, 0, 0, 1, 0, 1, 0, 1, 0);
        cyc(0, "load100", 1, 1, 100, 0, 0, 0, 100, 0, 0);
        cyc(0, "step0_up", 1, 0, 0, 1, 0, 0, 100, 0, 0);
        cyc(0, "step0_down", 1, 0, 0, 1, 1, 0, 100, 0, 0);
        cyc(0, "en0_step9", 1, 0, 0, 0, 0, 9, 100, 0, 0);
        cyc(0, "load195", 1, 1, 195, 0, 0, 0, 195, 0, 0);
        cyc(0, "wrap_up9", 1, 0, 0, 1, 0, 9, 3, 1, 0);
        cyc(0, "en0_clears", 1, 0, 0, 0, 1, 9, 3, 0, 0);
        // saturating counter: clamps, repeated clamp flag, exact landings
        cyc(1, "sat_load198", 1, 1, 198, 0, 0, 0, 198, 0, 0);
        cyc(1, "sat_up5", 1, 0, 0, 1, 0, 5, 200, 1, 0);
        cyc(1, "sat_up_at_max", 1, 0, 0, 1, 0, 1, 200, 1, 0);
        cyc(1, "sat_load3", 1, 1, 3, 0, 0, 0, 3, 0, 0);
        cyc(1, "sat_down7", 1, 0, 0, 1, 1, 7, 0, 0, 1);
        cyc(1, "sat_down_at_min", 1, 0, 0, 1, 1, 1, 0, 0, 1);
        cyc(1, "sat_up2", 1, 0, 0, 1, 0, 2, 2, 0, 0);
        cyc(1, "sat_load195", 1, 1, 195, 0, 0, 0, 195, 0, 0);
        cyc(1, "sat_land_max", 1, 0, 0, 1, 0, 5, 200, 0, 0);
        cyc(1, "sat_load5", 1, 1, 5, 0, 0, 0, 5, 0, 0);
        cyc(1, "sat_land_zero", 1, 0, 0, 1, 1, 5, 0, 0, 0);
        cyc(1, "sat_load_clamp", 1, 1, 250, 1, 0, 9, 200, 0, 0);
        // 32-bit default terminal value
        cyc(2, "w32_down_wrap", 1, 0, 0, 1, 1, 1, 32'hFFFF_FFFF, 0, 1);
        cyc(2, "w32_up_wrap", 1, 0, 0, 1, 0, 1, 0, 1, 0);
        cyc(2, "w32_up15", 1, 0, 0, 1, 0, 15, 15, 0, 0);
        cyc(2, "w32_down15", 1, 0, 0, 1, 1, 15, 0, 0, 0);
        cyc(2, "w32_loadF0", 1, 1, 32'hFFFF_FFF0, 0, 0, 0, 32'hFFFF_FFF0, 0, 0);
        cyc(2, "w32_land_max", 1, 0, 0, 1, 0, 15, 32'hFFFF_FFFF, 0, 0);
        @(negedge clk);
        idle_all();
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
